// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register.
// Captures execute results each cycle, holds them while the data-memory system
// stalls, squashes instructions on flush (deferring the flush if memory is busy),
// freezes into HALTED once a halt instruction retires from the slot, and keeps
// a saturating count of memory-stall cycles for debug.
module ex_mem_latch #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,            // active-low, asynchronous
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_ALUOut,
    input  logic [DATA_W-1:0] ex_WriteData,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemToReg,
    input  logic              ex_RegWrite,
    input  logic [REG_W-1:0]  ex_WriteReg,
    input  logic              ex_Halt,
    input  logic              mem_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] ALUOut,
    output logic [DATA_W-1:0] WriteData,
    output logic              Enable,
    output logic              MemWrite,
    output logic              MemToReg,
    output logic              RegWrite,
    output logic [REG_W-1:0]  WriteReg,
    output logic              Dump,
    output logic              valid,
    output logic              stall_upstream,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                flush_pending_q, flush_pending_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic                reg_write_q, reg_write_d;
    logic [REG_W-1:0]    write_reg_q, write_reg_d;
    logic                halt_q, halt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic                load_bubble;
    logic                load_ex;

    // Next-state selection: hold on stall, bubble on flush/halt, otherwise capture EX.
    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        load_bubble     = 1'b0;
        load_ex         = 1'b0;

        case (state_q)
            S_HALTED: begin
                // Frozen until reset; the slot only ever carries bubbles.
                load_bubble     = 1'b1;
                flush_pending_d = 1'b0;
            end
            default: begin
                if (mem_stall) begin
                    // The slot is mid-access; remember a flush for the next load.
                    state_d = S_STALL;
                    if (flush) begin
                        flush_pending_d = 1'b1;
                    end
                end else begin
                    state_d         = S_RUN;
                    flush_pending_d = 1'b0;
                    if (valid_q && halt_q) begin
                        // Halt retires from the slot on this edge.
                        load_bubble = 1'b1;
                        state_d     = S_HALTED;
                    end else if (flush || flush_pending_q) begin
                        load_bubble = 1'b1;
                    end else begin
                        load_ex = 1'b1;
                    end
                end
            end
        endcase

        valid_d      = valid_q;
        alu_d        = alu_q;
        wdata_d      = wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        halt_d       = halt_q;

        if (load_bubble) begin
            valid_d      = 1'b0;
            alu_d        = '0;
            wdata_d      = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
            write_reg_d  = '0;
            halt_d       = 1'b0;
        end else if (load_ex) begin
            // Data is copied unconditionally; control only for a real instruction.
            valid_d      = ex_valid;
            alu_d        = ex_ALUOut;
            wdata_d      = ex_WriteData;
            mem_read_d   = ex_valid & ex_MemRead;
            mem_write_d  = ex_valid & ex_MemWrite;
            mem_to_reg_d = ex_valid & ex_MemToReg;
            reg_write_d  = ex_valid & ex_RegWrite;
            write_reg_d  = ex_WriteReg;
            halt_d       = ex_valid & ex_Halt;
        end
    end

    // Saturating stall counter advances on every stalled edge, in any state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State, slot and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_RUN;
            flush_pending_q <= 1'b0;
            valid_q         <= 1'b0;
            alu_q           <= '0;
            wdata_q         <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_write_q     <= 1'b0;
            write_reg_q     <= '0;
            halt_q          <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            valid_q         <= valid_d;
            alu_q           <= alu_d;
            wdata_q         <= wdata_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_write_q     <= reg_write_d;
            write_reg_q     <= write_reg_d;
            halt_q          <= halt_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign ALUOut         = alu_q;
    assign WriteData      = wdata_q;
    assign Enable         = valid_q & (mem_read_q | mem_write_q);
    assign MemWrite       = valid_q & mem_write_q;
    assign MemToReg       = mem_to_reg_q;
    assign RegWrite       = reg_write_q;
    assign WriteReg       = write_reg_q;
    assign Dump           = valid_q & halt_q;
    assign valid          = valid_q;
    assign halted         = (state_q == S_HALTED);
    assign stall_upstream = mem_stall | halted;
    assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Bench for ex_mem_latch: directed vector table, async-reset and saturation
// sequences, then randomized traffic against a behavioural slot model.
// A second instance with a 4-bit counter exercises saturation quickly.
module tb_ex_mem_latch;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_ALUOut;
    logic [15:0] ex_WriteData;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemToReg;
    logic        ex_RegWrite;
    logic [2:0]  ex_WriteReg;
    logic        ex_Halt;
    logic        mem_stall;
    logic        flush;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] wd;
        logic        en;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic [2:0]  wr;
        logic        dump;
        logic        su;
        logic        halted;
        logic [15:0] cnt;
    } obs_t;

    logic [15:0] a_alu, a_wd, b_alu, b_wd;
    logic        a_en, a_mw, a_m2r, a_rw, a_dump, a_v, a_su, a_h;
    logic        b_en, b_mw, b_m2r, b_rw, b_dump, b_v, b_su, b_h;
    logic [2:0]  a_wr, b_wr;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    ex_mem_latch #(.DATA_W(16), .REG_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst_n), .ex_valid(ex_valid), .ex_ALUOut(ex_ALUOut),
        .ex_WriteData(ex_WriteData), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite), .ex_WriteReg(ex_WriteReg),
        .ex_Halt(ex_Halt), .mem_stall(mem_stall), .flush(flush),
        .ALUOut(a_alu), .WriteData(a_wd), .Enable(a_en), .MemWrite(a_mw),
        .MemToReg(a_m2r), .RegWrite(a_rw), .WriteReg(a_wr), .Dump(a_dump),
        .valid(a_v), .stall_upstream(a_su), .halted(a_h), .stall_cycles(a_cnt)
    );

    ex_mem_latch #(.DATA_W(16), .REG_W(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst_n), .ex_valid(ex_valid), .ex_ALUOut(ex_ALUOut),
        .ex_WriteData(ex_WriteData), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite), .ex_WriteReg(ex_WriteReg),
        .ex_Halt(ex_Halt), .mem_stall(mem_stall), .flush(flush),
        .ALUOut(b_alu), .WriteData(b_wd), .Enable(b_en), .MemWrite(b_mw),
        .MemToReg(b_m2r), .RegWrite(b_rw), .WriteReg(b_wr), .Dump(b_dump),
        .valid(b_v), .stall_upstream(b_su), .halted(b_h), .stall_cycles(b_cnt)
    );

    obs_t o_main, o_sat;
    assign o_main = {a_v, a_alu, a_wd, a_en, a_mw, a_m2r, a_rw, a_wr, a_dump, a_su, a_h, a_cnt};
    assign o_sat  = {b_v, b_alu, b_wd, b_en, b_mw, b_m2r, b_rw, b_wr, b_dump, b_su, b_h, 12'h000, b_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".valid"},    32'(a.valid),  32'(e.valid));
        chk({tag, ".ALUOut"},   32'(a.alu),    32'(e.alu));
        chk({tag, ".WriteData"},32'(a.wd),     32'(e.wd));
        chk({tag, ".Enable"},   32'(a.en),     32'(e.en));
        chk({tag, ".MemWrite"}, 32'(a.mw),     32'(e.mw));
        chk({tag, ".MemToReg"}, 32'(a.m2r),    32'(e.m2r));
        chk({tag, ".RegWrite"}, 32'(a.rw),     32'(e.rw));
        chk({tag, ".WriteReg"}, 32'(a.wr),     32'(e.wr));
        chk({tag, ".Dump"},     32'(a.dump),   32'(e.dump));
        chk({tag, ".stall_up"}, 32'(a.su),     32'(e.su));
        chk({tag, ".halted"},   32'(a.halted), 32'(e.halted));
        chk({tag, ".stall_cyc"},32'(a.cnt),    32'(e.cnt));
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        v;
        logic [15:0] alu;
        logic [15:0] wd;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic [2:0]  wr;
        logic        hlt;
    } slot_t;

    slot_t m_slot;
    bit    m_halted;
    bit    m_pend;
    int    m_cnt;
    int    m_cnt_s;

    task automatic model_reset();
        m_slot   = '0;
        m_halted = 0;
        m_pend   = 0;
        m_cnt    = 0;
        m_cnt_s  = 0;
    endtask

    // What the slot should hold after the coming rising edge, given current inputs.
    task automatic model_edge();
        if (mem_stall) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
        end
        if (m_halted) begin
            m_slot = '0;
            m_pend = 0;
        end else if (mem_stall) begin
            if (flush) m_pend = 1;
        end else begin
            if (m_slot.v && m_slot.hlt) begin
                m_slot   = '0;
                m_halted = 1;
            end else if (flush || m_pend) begin
                m_slot = '0;
            end else if (ex_valid) begin
                m_slot = '{1'b1, ex_ALUOut, ex_WriteData, ex_MemRead, ex_MemWrite,
                           ex_MemToReg, ex_RegWrite, ex_WriteReg, ex_Halt};
            end else begin
                m_slot = '{1'b0, ex_ALUOut, ex_WriteData, 1'b0, 1'b0, 1'b0, 1'b0,
                           ex_WriteReg, 1'b0};
            end
            m_pend = 0;
        end
    endtask

    function automatic obs_t exp_obs(input int cnt);
        obs_t e;
        e.valid  = m_slot.v;
        e.alu    = m_slot.alu;
        e.wd     = m_slot.wd;
        e.en     = m_slot.v & (m_slot.mr | m_slot.mw);
        e.mw     = m_slot.v & m_slot.mw;
        e.m2r    = m_slot.m2r;
        e.rw     = m_slot.rw;
        e.wr     = m_slot.wr;
        e.dump   = m_slot.v & m_slot.hlt;
        e.su     = mem_stall | m_halted;
        e.halted = m_halted;
        e.cnt    = 16'(cnt);
        return e;
    endfunction

    task automatic check_model(input string tag);
        chk_all({tag, ".main"}, o_main, exp_obs(m_cnt));
        chk_all({tag, ".sat"},  o_sat,  exp_obs(m_cnt_s));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic st, fl, ev;
        logic [15:0] alu, wd;
        logic mr, mw, m2r, rw;
        logic [2:0] wr;
        logic hlt;
        logic x_v;
        logic [15:0] x_alu, x_wd;
        logic x_en, x_mw, x_m2r, x_rw;
        logic [2:0] x_wr;
        logic x_dump, x_halted;
        int x_cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        obs_t e;
        int   sc;

        //        st fl ev alu      wd       mr mw m2r rw wr hl | v  alu      wd       en mw m2r rw wr dp hd cnt
        tbl[0]  = '{0, 0, 1, 16'h1234, 16'h0005, 0, 0, 0, 1, 3, 0,  1, 16'h1234, 16'h0005, 0, 0, 0, 1, 3, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 16'h0040, 16'hBEEF, 0, 1, 0, 0, 0, 0,  1, 16'h0040, 16'hBEEF, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 16'h0100, 16'h0000, 1, 0, 1, 1, 5, 0,  1, 16'h0040, 16'hBEEF, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 1, 16'h0100, 16'h0000, 1, 0, 1, 1, 5, 0,  1, 16'h0040, 16'hBEEF, 1, 1, 0, 0, 0, 0, 0, 2};
        tbl[4]  = '{1, 0, 1, 16'h0100, 16'h0000, 1, 0, 1, 1, 5, 0,  1, 16'h0040, 16'hBEEF, 1, 1, 0, 0, 0, 0, 0, 3};
        tbl[5]  = '{0, 0, 1, 16'h0100, 16'h0000, 1, 0, 1, 1, 5, 0,  1, 16'h0100, 16'h0000, 1, 0, 1, 1, 5, 0, 0, 3};
        tbl[6]  = '{0, 1, 1, 16'h2222, 16'h0000, 0, 0, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3};
        tbl[7]  = '{0, 0, 1, 16'h0300, 16'h0000, 1, 0, 1, 1, 1, 0,  1, 16'h0300, 16'h0000, 1, 0, 1, 1, 1, 0, 0, 3};
        tbl[8]  = '{1, 1, 1, 16'h4444, 16'h0000, 0, 0, 0, 1, 4, 0,  1, 16'h0300, 16'h0000, 1, 0, 1, 1, 1, 0, 0, 4};
        tbl[9]  = '{1, 0, 1, 16'h4444, 16'h0000, 0, 0, 0, 1, 4, 0,  1, 16'h0300, 16'h0000, 1, 0, 1, 1, 1, 0, 0, 5};
        tbl[10] = '{0, 0, 1, 16'h4444, 16'h0000, 0, 0, 0, 1, 4, 0,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5};
        tbl[11] = '{0, 0, 1, 16'h5555, 16'h0000, 0, 0, 0, 1, 6, 0,  1, 16'h5555, 16'h0000, 0, 0, 0, 1, 6, 0, 0, 5};
        tbl[12] = '{0, 0, 0, 16'h0AAA, 16'h0BBB, 1, 1, 1, 1, 5, 1,  0, 16'h0AAA, 16'h0BBB, 0, 0, 0, 0, 5, 0, 0, 5};
        tbl[13] = '{0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5};
        tbl[14] = '{0, 0, 1, 16'h6666, 16'h0000, 0, 0, 0, 1, 7, 0,  1, 16'h6666, 16'h0000, 0, 0, 0, 1, 7, 0, 0, 5};
        tbl[15] = '{0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1,  1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 5};
        tbl[16] = '{1, 0, 1, 16'h7777, 16'h0000, 0, 0, 0, 1, 2, 0,  1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 6};
        tbl[17] = '{0, 0, 1, 16'h7777, 16'h0000, 0, 0, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 6};
        tbl[18] = '{1, 0, 1, 16'h7777, 16'h0000, 0, 0, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 7};
        tbl[19] = '{0, 0, 1, 16'h7777, 16'h0000, 0, 0, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 7};

        rst_n = 1'b0;
        ex_valid = 0; ex_ALUOut = '0; ex_WriteData = '0; ex_MemRead = 0; ex_MemWrite = 0;
        ex_MemToReg = 0; ex_RegWrite = 0; ex_WriteReg = '0; ex_Halt = 0;
        mem_stall = 0; flush = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        $display("reset: valid=%b su=%b halted=%b cnt=%0d", a_v, a_su, a_h, a_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            mem_stall    = tbl[i].st;
            flush        = tbl[i].fl;
            ex_valid     = tbl[i].ev;
            ex_ALUOut    = tbl[i].alu;
            ex_WriteData = tbl[i].wd;
            ex_MemRead   = tbl[i].mr;
            ex_MemWrite  = tbl[i].mw;
            ex_MemToReg  = tbl[i].m2r;
            ex_RegWrite  = tbl[i].rw;
            ex_WriteReg  = tbl[i].wr;
            ex_Halt      = tbl[i].hlt;
            @(posedge clk);
            #1;
            e = '{tbl[i].x_v, tbl[i].x_alu, tbl[i].x_wd, tbl[i].x_en, tbl[i].x_mw,
                  tbl[i].x_m2r, tbl[i].x_rw, tbl[i].x_wr, tbl[i].x_dump,
                  tbl[i].st | tbl[i].x_halted, tbl[i].x_halted, 16'(tbl[i].x_cnt)};
            chk_all($sformatf("vec%0d.main", i), o_main, e);
            sc = (tbl[i].x_cnt > 15) ? 15 : tbl[i].x_cnt;
            e.cnt = 16'(sc);
            chk_all($sformatf("vec%0d.sat", i), o_sat, e);
            $display("vec %0d st=%b fl=%b ev=%b -> valid=%b alu=%h en=%b dump=%b halted=%b cnt=%0d",
                     i, mem_stall, flush, ex_valid, a_v, a_alu, a_en, a_dump, a_h, a_cnt);
        end

        // Async reset while HALTED and stalling: cleared with no clock edge.
        mem_stall = 1'b1;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model("rst_halted");
        mem_stall = 1'b0;
        #1;
        check_model("rst_halted_nostall");
        $display("async reset from HALTED: valid=%b halted=%b su=%b cnt=%0d", a_v, a_h, a_su, a_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 20 stalled cycles, small counter pins at 15.
        ex_valid = 1; ex_ALUOut = 16'h0040; ex_WriteData = 16'hBEEF; ex_MemWrite = 1;
        ex_MemRead = 0; ex_MemToReg = 0; ex_RegWrite = 0; ex_WriteReg = 0; ex_Halt = 0; flush = 0;
        cycle("sat_load");
        mem_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle($sformatf("sat%0d", i));
            $display("sat %0d: cnt16=%0d cnt4=%0d", i, a_cnt, b_cnt);
        end
        // Reset mid-stall.
        #2;
        async_reset("rst_midstall");
        $display("async reset mid-stall: valid=%b en=%b cnt=%0d", a_v, a_en, a_cnt);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            mem_stall    = ($urandom_range(0, 9) < 3);
            flush        = ($urandom_range(0, 9) == 0);
            ex_valid     = ($urandom_range(0, 7) != 0);
            ex_ALUOut    = 16'($urandom);
            ex_WriteData = 16'($urandom);
            ex_MemRead   = 1'($urandom);
            ex_MemWrite  = 1'($urandom);
            ex_MemToReg  = 1'($urandom);
            ex_RegWrite  = 1'($urandom);
            ex_WriteReg  = 3'($urandom);
            ex_Halt      = ($urandom_range(0, 15) == 0);
            cycle($sformatf("rnd%0d", n));
            $display("rnd %0d st=%b fl=%b ev=%b hlt=%b -> valid=%b dump=%b halted=%b cnt=%0d",
                     n, mem_stall, flush, ex_valid, ex_Halt, a_v, a_dump, a_h, a_cnt);
            if ((m_halted && $urandom_range(0, 3) == 0) || (n % 97 == 96)) begin
                async_reset($sformatf("rnd_rst%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
